// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, constants and helpers for the clock divider.
//   ctrl_state_e  - control FSM states (APPLY, WAIT_LOCK, LOCKED)
//   DIV_MIN       - smallest usable divide ratio
//   sanitizeDiv   - clamps a requested ratio up to DIV_MIN
//   sanitizePhase - forces an out-of-range phase offset back to 0
package clk_div_pkg;

  typedef enum logic [1:0] {
    APPLY     = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2
  } ctrl_state_e;

  localparam int DIV_MIN = 2;

  // The helpers work on a wide fixed width so that any DIV_W up to 32 can
  // share them; callers zero-extend in and truncate back out.
  localparam int SAN_W = 32;

  // Ratios of 0 and 1 cannot produce a toggling output, so they clamp up.
  function automatic logic [SAN_W-1:0] sanitizeDiv(input logic [SAN_W-1:0] divReq);
    if (divReq < SAN_W'(DIV_MIN)) begin
      return SAN_W'(DIV_MIN);
    end
    return divReq;
  endfunction

  // A phase must name a counter value that actually occurs in the cycle.
  function automatic logic [SAN_W-1:0] sanitizePhase(input logic [SAN_W-1:0] phaseReq,
                                                     input logic [SAN_W-1:0] divEff);
    if (phaseReq >= divEff) begin
      return '0;
    end
    return phaseReq;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divided-clock channel with its own shadow ratio/phase.
//   clk, rst   - system clock, synchronous active-high reset
//   en_i       - run enable; when low the counter parks at the phase value
//   realign_i  - reload counter with phase (shared strobe from control FSM)
//   wr_i       - load shadow div/phase from div_i/phase_i (already sanitised)
//   clkout_o   - registered divided clock, high while cnt < div/2
//   tick_o     - registered pulse while cnt == 0
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             realign_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             clkout_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;

  // Next-state for shadow registers, counter and outputs. The outputs are
  // computed from the next counter value so that, once registered, they line
  // up with the counter in the same cycle. The wrap test uses >= so a counter
  // left above a freshly shrunk ratio still returns to 0.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (wr_i) begin
      div_d   = div_i;
      phase_d = phase_i;
    end

    if (realign_i || !en_i) begin
      cnt_d = phase_q;
    end else if (cnt_q >= div_q - DIV_W'(1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    clkout_d = en_i && (cnt_d < (div_d >> 1));
    tick_d   = en_i && (cnt_d == '0);
  end

  // Channel state register with synchronous reset to the minimum ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_W'(DIV_MIN);
      phase_q  <= '0;
      cnt_q    <= '0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign clkout_o = clkout_q;
  assign tick_o   = tick_q;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock divider with lock indication.
//   clk, rst    - system clock, synchronous active-high reset
//   cfg_valid   - configuration write request
//   cfg_ready   - write accepted when high together with cfg_valid
//   cfg_ch      - target channel; values >= NUM_CH are accepted and dropped
//   cfg_div     - divide ratio (0 and 1 behave as 2)
//   cfg_phase   - phase offset in clk cycles (>= ratio behaves as 0)
//   ch_en       - per-channel run enable
//   clkout      - registered divided clocks
//   tick        - one-cycle pulse on each clkout rising edge
//   locked      - all channels realigned and settled
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [DIV_W-1:0]          cfg_phase,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH-1:0]         clkout,
  output logic [NUM_CH-1:0]         tick,
  output logic                      locked
);

  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

  ctrl_state_e       state_q, state_d;
  logic [LCNT_W-1:0] lockCnt_q, lockCnt_d;
  logic              cfgWrite;
  logic              realign;
  logic [DIV_W-1:0]  divEff;
  logic [DIV_W-1:0]  phaseEff;

  // Writes are accepted in every state except APPLY; only in-range channels
  // actually disturb the FSM and shadow registers.
  assign cfg_ready = (state_q != APPLY);
  assign cfgWrite  = cfg_valid && cfg_ready && (int'(cfg_ch) < NUM_CH);
  assign realign   = (state_q == APPLY);
  assign locked    = (state_q == LOCKED);

  // Phase is checked against the clamped ratio, not the raw request.
  assign divEff   = DIV_W'(sanitizeDiv(SAN_W'(cfg_div)));
  assign phaseEff = DIV_W'(sanitizePhase(SAN_W'(cfg_phase), SAN_W'(divEff)));

  // Control FSM next state: APPLY lasts one cycle, then the lock counter
  // runs; any in-range write restarts the whole sequence.
  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    case (state_q)
      APPLY: begin
        state_d   = WAIT_LOCK;
        lockCnt_d = '0;
      end
      WAIT_LOCK: begin
        if (cfgWrite) begin
          state_d = APPLY;
        end else begin
          lockCnt_d = lockCnt_q + LCNT_W'(1);
          if (lockCnt_q == LCNT_W'(LOCK_CYCLES - 1)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (cfgWrite) begin
          state_d = APPLY;
        end
      end
      default: begin
        state_d   = WAIT_LOCK;
        lockCnt_d = '0;
      end
    endcase
  end

  // Control FSM state register; reset discards any lock progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      lockCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (ch_en[i]),
      .realign_i(realign),
      .wr_i     (cfgWrite && (int'(cfg_ch) == i)),
      .div_i    (divEff),
      .phase_i  (phaseEff),
      .clkout_o (clkout[i]),
      .tick_o   (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed self-checking bench for clk_div_gen.
// Main instance uses the default 4 channels; a 5-channel instance provides a
// 3-bit cfg_ch so that out-of-range channel numbers can be driven.
module tb_clk_div_gen;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic [3:0] ch_en;
  logic [3:0] clkout;
  logic [3:0] tick;
  logic       locked;

  logic       cfg_valid5;
  logic       cfg_ready5;
  logic [2:0] cfg_ch5;
  logic [7:0] cfg_div5;
  logic [7:0] cfg_phase5;
  logic [4:0] ch_en5;
  logic [4:0] clkout5;
  logic [4:0] tick5;
  logic       locked5;

  int checks = 0;
  int passes = 0;
  int edgeCnt = 0;

  clk_div_gen dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .ch_en    (ch_en),
    .clkout   (clkout),
    .tick     (tick),
    .locked   (locked)
  );

  clk_div_gen #(.NUM_CH(5)) dut5 (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid5),
    .cfg_ready(cfg_ready5),
    .cfg_ch   (cfg_ch5),
    .cfg_div  (cfg_div5),
    .cfg_phase(cfg_phase5),
    .ch_en    (ch_en5),
    .clkout   (clkout5),
    .tick     (tick5),
    .locked   (locked5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release; the 5-channel instance is never
  // reconfigured, so its outputs follow this count directly.
  always @(posedge clk) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one write on the main instance; returns 1 ns after the accepting edge.
  task automatic write_cfg(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph);
    int waitCnt = 0;
    while (cfg_ready !== 1'b1 && waitCnt < 20) begin
      step(1);
      waitCnt++;
    end
    checks++;
    if (cfg_ready !== 1'b1) $display("[TB] FAIL write_ready actual=%b required=1", cfg_ready);
    else passes++;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_phase = ph;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    cfg_valid5 = 1'b0; cfg_ch5 = '0; cfg_div5 = '0; cfg_phase5 = '0;
    ch_en = 4'hF;
    ch_en5 = 5'h1F;
    step(3);
    checks++;
    if (clkout !== 4'h0 || tick !== 4'h0 || locked !== 1'b0 || cfg_ready !== 1'b1)
      $display("[TB] FAIL reset_state actual=clk%h tick%h lock%b rdy%b required=clk0 tick0 lock0 rdy1",
               clkout, tick, locked, cfg_ready);
    else passes++;
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      logic [3:0] expClk;
      step(1);
      expClk = (n % 2 == 0) ? 4'hF : 4'h0;
      checks++;
      if (clkout !== expClk || tick !== expClk)
        $display("[TB] FAIL reset_div2 n=%0d actual=clk%h tick%h required=%h", n, clkout, tick, expClk);
      else passes++;
      checks++;
      if (locked !== (n >= 16))
        $display("[TB] FAIL reset_lock n=%0d actual=%b required=%b", n, locked, (n >= 16));
      else passes++;
    end
  endtask

  task automatic test_div5;
    write_cfg(2'd1, 8'd5, 8'd0);
    checks++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0)
      $display("[TB] FAIL div5_apply actual=lock%b rdy%b required=lock0 rdy0", locked, cfg_ready);
    else passes++;
    for (int k = 0; k <= 20; k++) begin
      step(1);
      checks++;
      if (clkout[1] !== ((k % 5) < 2) || tick[1] !== ((k % 5) == 0))
        $display("[TB] FAIL div5_ch1 k=%0d actual=clk%b tick%b required=clk%b tick%b",
                 k, clkout[1], tick[1], ((k % 5) < 2), ((k % 5) == 0));
      else passes++;
      checks++;
      if (clkout[0] !== ((k % 2) == 0))
        $display("[TB] FAIL div5_ch0 k=%0d actual=%b required=%b", k, clkout[0], ((k % 2) == 0));
      else passes++;
      checks++;
      if (locked !== (k >= 16))
        $display("[TB] FAIL div5_lock k=%0d actual=%b required=%b", k, locked, (k >= 16));
      else passes++;
    end
  endtask

  task automatic test_phase;
    write_cfg(2'd0, 8'd4, 8'd0);
    write_cfg(2'd2, 8'd4, 8'd2);
    for (int k = 0; k < 8; k++) begin
      step(1);
      checks++;
      if (clkout[0] !== ((k % 4) < 2) || clkout[2] !== (((k + 2) % 4) < 2) ||
          tick[2] !== (((k + 2) % 4) == 0))
        $display("[TB] FAIL phase180 k=%0d actual=c0%b c2%b t2%b required=c0%b c2%b t2%b",
                 k, clkout[0], clkout[2], tick[2],
                 ((k % 4) < 2), (((k + 2) % 4) < 2), (((k + 2) % 4) == 0));
      else passes++;
    end
  endtask

  task automatic test_sanitize;
    write_cfg(2'd3, 8'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      step(1);
      checks++;
      if (clkout[3] !== ((k % 2) == 0))
        $display("[TB] FAIL div0 k=%0d actual=%b required=%b", k, clkout[3], ((k % 2) == 0));
      else passes++;
    end
    write_cfg(2'd3, 8'd1, 8'd0);
    for (int k = 0; k < 6; k++) begin
      step(1);
      checks++;
      if (clkout[3] !== ((k % 2) == 0) || tick[3] !== ((k % 2) == 0))
        $display("[TB] FAIL div1 k=%0d actual=clk%b tick%b required=%b", k, clkout[3], tick[3], ((k % 2) == 0));
      else passes++;
    end
    write_cfg(2'd3, 8'd6, 8'd9);
    for (int k = 0; k < 8; k++) begin
      step(1);
      checks++;
      if (clkout[3] !== ((k % 6) < 3) || tick[3] !== ((k % 6) == 0))
        $display("[TB] FAIL phase9 k=%0d actual=clk%b tick%b required=clk%b tick%b",
                 k, clkout[3], tick[3], ((k % 6) < 3), ((k % 6) == 0));
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    write_cfg(2'd0, 8'd4, 8'd0);
    step(1);
    step(5);
    write_cfg(2'd0, 8'd4, 8'd0);
    for (int k = 1; k <= 17; k++) begin
      step(1);
      checks++;
      if (locked !== (k >= 17))
        $display("[TB] FAIL b2b_lock k=%0d actual=%b required=%b", k, locked, (k >= 17));
      else passes++;
    end
  endtask

  task automatic test_disable;
    write_cfg(2'd3, 8'd6, 8'd3);
    step(1);
    ch_en = 4'b0111;
    for (int j = 1; j <= 6; j++) begin
      step(1);
      checks++;
      if (clkout[3] !== 1'b0 || tick[3] !== 1'b0 || locked !== 1'b0)
        $display("[TB] FAIL disabled j=%0d actual=clk%b tick%b lock%b required=0 0 0",
                 j, clkout[3], tick[3], locked);
      else passes++;
    end
    ch_en = 4'hF;
    for (int j = 0; j < 12; j++) begin
      int c;
      step(1);
      c = (4 + j) % 6;
      checks++;
      if (clkout[3] !== (c < 3) || tick[3] !== (c == 0))
        $display("[TB] FAIL reenable j=%0d actual=clk%b tick%b required=clk%b tick%b",
                 j, clkout[3], tick[3], (c < 3), (c == 0));
      else passes++;
      checks++;
      if (locked !== ((8 + j) >= 17))
        $display("[TB] FAIL en_lock j=%0d actual=%b required=%b", j, locked, ((8 + j) >= 17));
      else passes++;
    end
  endtask

  task automatic test_invalid_ch;
    logic [2:0] badCh [2];
    badCh[0] = 3'd7;
    badCh[1] = 3'd5;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (cfg_ready5 !== 1'b1 || locked5 !== 1'b1)
        $display("[TB] FAIL badch_pre ch=%0d actual=rdy%b lock%b required=1 1", badCh[b], cfg_ready5, locked5);
      else passes++;
      cfg_valid5 = 1'b1;
      cfg_ch5    = badCh[b];
      cfg_div5   = 8'd5;
      cfg_phase5 = 8'd1;
      step(1);
      cfg_valid5 = 1'b0;
      for (int k = 0; k < 6; k++) begin
        logic [4:0] expClk;
        expClk = (edgeCnt % 2 == 0) ? 5'h1F : 5'h00;
        checks++;
        if (locked5 !== 1'b1 || cfg_ready5 !== 1'b1 || clkout5 !== expClk || tick5 !== expClk)
          $display("[TB] FAIL badch ch=%0d k=%0d actual=lock%b rdy%b clk%h tick%h required=lock1 rdy1 clk%h",
                   badCh[b], k, locked5, cfg_ready5, clkout5, tick5, expClk);
        else passes++;
        step(1);
      end
    end
  endtask

  task automatic test_reset_mid;
    write_cfg(2'd1, 8'd5, 8'd1);
    step(4);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 8'd7;
    cfg_phase = 8'd1;
    step(1);
    checks++;
    if (clkout !== 4'h0 || tick !== 4'h0 || locked !== 1'b0 || cfg_ready !== 1'b1)
      $display("[TB] FAIL rstmid_state actual=clk%h tick%h lock%b rdy%b required=clk0 tick0 lock0 rdy1",
               clkout, tick, locked, cfg_ready);
    else passes++;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      logic [3:0] expClk;
      step(1);
      expClk = (n % 2 == 0) ? 4'hF : 4'h0;
      checks++;
      if (clkout !== expClk || tick !== expClk || locked !== (n >= 16))
        $display("[TB] FAIL rstmid_run n=%0d actual=clk%h tick%h lock%b required=clk%h lock%b",
                 n, clkout, tick, locked, expClk, (n >= 16));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_div5();
    test_phase();
    test_sanitize();
    test_back_to_back();
    test_disable();
    test_invalid_ch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
